// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } irq_state_t;

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_MASK    = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;

  localparam logic [3:0] VEC_NONE    = 4'h0;

endpackage

// File: rtl/irq_edge_detect.sv
// rtl/irq_edge_detect.sv - per-bit rising-edge detector, one-cycle pulse out
module irq_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_pulse
);

  logic [WIDTH-1:0] r_prev;

  // Remember last cycle's level so a held level produces only one pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev <= '0;
    else        r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - vectored interrupt controller; optional timeout via IRQ_CTRL_TIMEOUT_EN
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC        = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0020,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [3:0]         interrupt_vector,
  input  logic               interrupt_done,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data,
  output logic               irq_selected
);

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_done_clr;
  irq_state_t         r_state;
  logic [3:0]         r_vec;
  logic [3:0]         r_act_idx;
  logic [3:0]         w_sel_idx;
  logic               w_hit;
  logic               w_done_hit;
  logic               w_tmo;
  logic               w_tmo_sticky;
  logic               w_busy;
  logic [63:0]        w_base;
  logic [63:0]        w_off;
  logic [3:0]         w_off4;
  logic               w_wr;
  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_wr_stat;
  logic [63:0]        w_rdata;
  logic               w_unused;

  irq_edge_detect #(.WIDTH(NUM_SRC)) u_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (irq_src),
    .o_pulse (w_edge)
  );

  assign w_base       = {32'h0, BASE_ADDR};
  assign w_off        = bus_address - w_base;
  assign w_off4       = w_off[3:0];
  assign irq_selected = (bus_address >= w_base) && (bus_address <= w_base + 64'd8);
  assign w_wr         = irq_selected && bus_write_enable;
  assign w_wr_pend    = w_wr && (w_off4 == OFF_PENDING);
  assign w_wr_mask    = w_wr && (w_off4 == OFF_MASK);
  assign w_wr_stat    = w_wr && (w_off4 == OFF_STATUS);
  assign w_w1c        = w_wr_pend ? bus_write_data[NUM_SRC-1:0] : '0;
  assign w_req        = r_pending & r_mask;
  assign w_hit        = |w_req;
  assign w_done_hit   = (r_state == ST_ASSERT) && interrupt_done;
  assign w_busy       = (r_state == ST_ASSERT);
  assign w_unused     = ^{w_off[63:4], bus_write_data, 32'(TIMEOUT_CYCLES)};

  // Lowest-index enabled pending source wins arbitration
  always_comb begin
    w_sel_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_sel_idx = 4'(i);
    end
  end

  // One-hot clear of the acknowledged source
  always_comb begin
    w_done_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_done_clr[i] = w_done_hit && (r_act_idx == 4'(i));
    end
  end

`ifdef IRQ_CTRL_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_tmo_sticky;

  assign w_tmo = (r_state == ST_ASSERT) && !interrupt_done &&
                 (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign w_tmo_sticky = r_tmo_sticky;

  // Count cycles spent waiting for an acknowledge; restart on every new vector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     r_tmo_cnt <= '0;
    else if (r_state != ST_ASSERT || w_done_hit || w_tmo) r_tmo_cnt <= '0;
    else                                            r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             r_tmo_sticky <= 1'b0;
    else if (w_tmo)                         r_tmo_sticky <= 1'b1;
    else if (w_wr_stat && bus_write_data[1]) r_tmo_sticky <= 1'b0;
  end
`else
  assign w_tmo        = 1'b0;
  assign w_tmo_sticky = 1'b0;
`endif

  // Pending bits: new edges always win over W1C and acknowledge clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_w1c & ~w_done_clr) | w_edge;
  end

  // Mask register, all sources enabled out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_mask <= '1;
    else if (w_wr_mask) r_mask <= bus_write_data[NUM_SRC-1:0];
  end

  // Vector FSM; GAP arbitrates on its way out so only one zero cycle separates vectors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_vec     <= VEC_NONE;
      r_act_idx <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_hit) begin
            r_act_idx <= w_sel_idx;
            r_vec     <= w_sel_idx + 4'd1;
            r_state   <= ST_ASSERT;
          end else begin
            r_vec     <= VEC_NONE;
            r_state   <= ST_IDLE;
          end
        end
        ST_ASSERT: begin
          if (w_done_hit || w_tmo) begin
            r_vec   <= VEC_NONE;
            r_state <= ST_GAP;
          end
        end
        default: begin
          r_vec   <= VEC_NONE;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt_vector = r_vec;

  // Combinational register read, zero outside an enabled read of the window
  always_comb begin
    w_rdata = '0;
    if (irq_selected && bus_read_enable) begin
      case (w_off4)
        OFF_PENDING: w_rdata[NUM_SRC-1:0] = r_pending;
        OFF_MASK:    w_rdata[NUM_SRC-1:0] = r_mask;
        OFF_STATUS:  w_rdata[7:0] = {r_vec, 2'b00, w_tmo_sticky, w_busy};
        default:     w_rdata = '0;
      endcase
    end
  end

  assign bus_read_data = w_rdata;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

  localparam logic [63:0] BASE = 64'h8000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic [3:0]  interrupt_vector;
  logic        interrupt_done;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        irq_selected;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(
    .NUM_SRC        (4),
    .BASE_ADDR      (32'h8000_0020),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_src          (irq_src),
    .interrupt_vector (interrupt_vector),
    .interrupt_done   (interrupt_done),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .irq_selected     (irq_selected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reg(input string tag, input logic [63:0] off, input logic [63:0] exp);
    logic [63:0] d;
    bus_address     = BASE + off;
    bus_read_enable = 1'b1;
    #1;
    d = bus_read_data;
    bus_read_enable = 1'b0;
    #1;
    check(tag, d, exp);
  endtask

  task automatic bus_write(input logic [63:0] off, input logic [63:0] data);
    bus_address      = BASE + off;
    bus_write_data   = data;
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
    bus_write_data   = '0;
  endtask

  task automatic ack();
    interrupt_done = 1'b1;
    tick();
    interrupt_done = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    irq_src          = '0;
    interrupt_done   = 1'b0;
    bus_address      = BASE;
    bus_write_data   = '0;
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
    tick(3);

    // Reset state and address window
    check("rst_vec", 64'(interrupt_vector), 64'h0);
    check_reg("rst_pending", 64'h0, 64'h0);
    check_reg("rst_mask", 64'h4, 64'hF);
    check_reg("rst_status", 64'h8, 64'h0);
    bus_address = BASE + 64'h8; #1;
    check("sel_top", 64'(irq_selected), 64'h1);
    check("rd_gated", bus_read_data, 64'h0);
    bus_address = BASE + 64'h9; #1;
    check("sel_above", 64'(irq_selected), 64'h0);
    bus_address = BASE - 64'h4; #1;
    check("sel_below", 64'(irq_selected), 64'h0);
    bus_address = BASE + 64'h10; bus_read_enable = 1'b1; #1;
    check("rd_outside", bus_read_data, 64'h0);
    bus_read_enable = 1'b0;

    reset = 1'b1;
    tick();

    // Single pulse on src0
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    check_reg("p1_pending", 64'h0, 64'h1);
    check("p1_vec_wait", 64'(interrupt_vector), 64'h0);
    tick();
    check("p1_vec", 64'(interrupt_vector), 64'h1);
    check_reg("p1_status", 64'h8, 64'h11);
    ack();
    check("p1_gap", 64'(interrupt_vector), 64'h0);
    check_reg("p1_pending_clr", 64'h0, 64'h0);
    tick();
    check("p1_idle", 64'(interrupt_vector), 64'h0);

    // Simultaneous src2/src1: lowest index first, one GAP cycle between
    irq_src = 4'b0110; tick(); irq_src = 4'b0000;
    tick();
    check("pr_first", 64'(interrupt_vector), 64'h2);
    ack();
    check("pr_gap", 64'(interrupt_vector), 64'h0);
    check_reg("pr_pending", 64'h0, 64'h4);
    tick();
    check("pr_second", 64'(interrupt_vector), 64'h3);
    ack();
    tick();
    check("pr_idle", 64'(interrupt_vector), 64'h0);

    // Held level raises exactly one event
    irq_src = 4'b1000; tick(2);
    check("lvl_vec", 64'(interrupt_vector), 64'h4);
    ack();
    tick(3);
    check("lvl_no_retrigger", 64'(interrupt_vector), 64'h0);
    check_reg("lvl_pending", 64'h0, 64'h0);
    irq_src = 4'b0000; tick();

    // Masked source stays pending until unmasked; mask change during ASSERT holds vector
    bus_write(64'h4, 64'hE);
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    tick(2);
    check("msk_novec", 64'(interrupt_vector), 64'h0);
    check_reg("msk_pending", 64'h0, 64'h1);
    bus_write(64'h4, 64'hF);
    tick();
    check("msk_vec", 64'(interrupt_vector), 64'h1);
    bus_write(64'h4, 64'hE);
    check("msk_hold", 64'(interrupt_vector), 64'h1);
    ack();
    check("msk_gap", 64'(interrupt_vector), 64'h0);
    bus_write(64'h4, 64'hF);

    // Acknowledge coincident with a new src0 edge
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    tick();
    check("co_vec", 64'(interrupt_vector), 64'h1);
    irq_src = 4'b0001; interrupt_done = 1'b1; tick();
    irq_src = 4'b0000; interrupt_done = 1'b0;
    check("co_gap", 64'(interrupt_vector), 64'h0);
    check_reg("co_pending", 64'h0, 64'h1);
    tick();
    check("co_again", 64'(interrupt_vector), 64'h1);
    ack();
    tick();
    check_reg("co_pending_clr", 64'h0, 64'h0);

    // W1C racing a new edge, and done outside ASSERT
    bus_write(64'h4, 64'h0);
    irq_src = 4'b0100; tick(); irq_src = 4'b0000; tick();
    ack();
    check_reg("done_ignored", 64'h0, 64'h4);
    irq_src = 4'b0100;
    bus_write(64'h0, 64'h4);
    irq_src = 4'b0000;
    check_reg("w1c_edge_wins", 64'h0, 64'h4);
    bus_write(64'h0, 64'h4);
    check_reg("w1c_clear", 64'h0, 64'h0);
    check("w1c_novec", 64'(interrupt_vector), 64'h0);
    bus_write(64'h4, 64'hF);

    // Unacknowledged vector
    irq_src = 4'b0001; tick(); irq_src = 4'b0000;
    tick();
    check("to_vec", 64'(interrupt_vector), 64'h1);
`ifdef IRQ_CTRL_TIMEOUT_EN
    tick(7);
    check("to_held", 64'(interrupt_vector), 64'h1);
    tick();
    check("to_drop", 64'(interrupt_vector), 64'h0);
    check_reg("to_status", 64'h8, 64'h2);
    tick();
    check("to_reassert", 64'(interrupt_vector), 64'h1);
    ack();
    tick();
    bus_write(64'h8, 64'h2);
    check_reg("to_status_clr", 64'h8, 64'h0);
`else
    tick(12);
    check("to_wait", 64'(interrupt_vector), 64'h1);
    check_reg("to_status", 64'h8, 64'h11);
    ack();
    tick();
`endif
    check_reg("to_pending", 64'h0, 64'h0);

    // Reset in the middle of ASSERT
    bus_write(64'h4, 64'h7);
    irq_src = 4'b0101; tick(); irq_src = 4'b0000;
    tick();
    check("ar_vec", 64'(interrupt_vector), 64'h1);
    reset = 1'b0; #1;
    check("ar_async_drop", 64'(interrupt_vector), 64'h0);
    tick(2);
    reset = 1'b1;
    tick();
    check_reg("ar_pending", 64'h0, 64'h0);
    check_reg("ar_mask", 64'h4, 64'hF);
    check_reg("ar_status", 64'h8, 64'h0);
    tick(2);
    check("ar_vec_after", 64'(interrupt_vector), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
